// File: rtl/ram_port_initiator_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_initiator_if
// Purpose  : Bundles the command, write-stream, read-stream, status and RAM
//            port signals of ram_port_initiator into one interface.
// Modports : master - the initiator side (accepts commands, drives the RAM).
//            slave  - the environment side (client datapath plus RAM port).
// Ports    : none (signals only). Parameters ADDR_W / DATA_W size the
//            address and data fields.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_port_initiator_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) ();

   // command channel
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] cmd_len;

   // write data stream
   logic              wdata_valid;
   logic              wdata_ready;
   logic [DATA_W-1:0] wdata;

   // read data stream
   logic              rdata_valid;
   logic              rdata_ready;
   logic [DATA_W-1:0] rdata;
   logic              rdata_last;

   // status pulses
   logic              done;
   logic              err;

   // RAM port
   logic              ram_en;
   logic              ram_wr;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
      input  wdata_valid, wdata,
      input  rdata_ready,
      input  ram_dout,
      output cmd_ready,
      output wdata_ready,
      output rdata_valid, rdata, rdata_last,
      output done, err,
      output ram_en, ram_wr, ram_addr, ram_din
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_len,
      output wdata_valid, wdata,
      output rdata_ready,
      output ram_dout,
      input  cmd_ready,
      input  wdata_ready,
      input  rdata_valid, rdata, rdata_last,
      input  done, err,
      input  ram_en, ram_wr, ram_addr, ram_din
   );

endinterface
`default_nettype wire

// File: rtl/ram_port_initiator.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_initiator
// Purpose  : Burst initiator for one port of the 8x8 dual-port RAM. Accepts a
//            write/read burst command, streams write data into the RAM, or
//            streams RAM contents out through a 2-entry read buffer.
// Ports    : clk   - clock (also clocks the attached RAM port)
//            rst_n - asynchronous active-low reset
//            bus   - ram_port_initiator_if.master: command, wdata stream,
//                    rdata stream, done/err pulses and RAM port drive
// Option   : RAM_INIT_ADDR_WRAP_EN - when defined, bursts wrap past the top
//            address; when undefined, such commands are rejected with err.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_initiator #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   ram_port_initiator_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_beatsLeft;     // beats remaining minus one
   logic              r_inflight;      // read issued last cycle, data on ram_dout now
   logic              r_inflightLast;  // that read was the final beat
   logic [DATA_W-1:0] r_bufData [2];
   logic [1:0]        r_bufLast;
   logic              r_rdIdx;
   logic              r_wrIdx;
   logic [1:0]        r_count;
   logic              r_done;

   logic              w_lastBeat;
   logic              w_pop;
   logic              w_writeBeat;
   logic              w_readIssue;
   logic              w_cmdReject;
   logic [2:0]        w_occupancy;

   assign w_lastBeat  = (r_beatsLeft == '0);
   assign w_pop       = bus.rdata_valid & bus.rdata_ready;
   assign w_writeBeat = (r_state == ST_WRITE) & bus.wdata_valid;

   // Slots already committed (buffered + in flight) minus the one leaving
   // this cycle must stay below 2, otherwise the returning data has no home.
   assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
   assign w_readIssue = (r_state == ST_READ) &&
                        (w_occupancy < (3'd2 + {2'b00, w_pop}));

`ifdef RAM_INIT_ADDR_WRAP_EN
   assign w_cmdReject = 1'b0;
   assign bus.err     = 1'b0;
`else
   localparam logic [ADDR_W:0] c_TOP_ADDR = {1'b0, {ADDR_W{1'b1}}};
   logic [ADDR_W:0] w_cmdEnd;
   logic            r_err;

   // One extra bit so a burst running past the top address is visible.
   assign w_cmdEnd    = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
   assign w_cmdReject = (w_cmdEnd > c_TOP_ADDR);
   assign bus.err     = r_err;
`endif

   // handshakes and RAM drive
   assign bus.cmd_ready   = (r_state == ST_IDLE);
   assign bus.wdata_ready = (r_state == ST_WRITE);
   assign bus.ram_en      = w_writeBeat | w_readIssue;
   assign bus.ram_wr      = w_writeBeat;
   assign bus.ram_addr    = bus.ram_en ? r_ptr : '0;
   assign bus.ram_din     = w_writeBeat ? bus.wdata : '0;

   // read stream straight from the buffer head; held until popped
   assign bus.rdata_valid = (r_count != 2'd0);
   assign bus.rdata       = r_bufData[r_rdIdx];
   assign bus.rdata_last  = bus.rdata_valid & r_bufLast[r_rdIdx];
   assign bus.done        = r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_ptr          <= '0;
         r_beatsLeft    <= '0;
         r_inflight     <= 1'b0;
         r_inflightLast <= 1'b0;
         r_bufData[0]   <= '0;
         r_bufData[1]   <= '0;
         r_bufLast      <= 2'b00;
         r_rdIdx        <= 1'b0;
         r_wrIdx        <= 1'b0;
         r_count        <= 2'd0;
         r_done         <= 1'b0;
`ifndef RAM_INIT_ADDR_WRAP_EN
         r_err          <= 1'b0;
`endif
      end else begin
         r_done         <= 1'b0;
`ifndef RAM_INIT_ADDR_WRAP_EN
         r_err          <= 1'b0;
`endif
         r_inflight     <= w_readIssue;
         r_inflightLast <= w_readIssue & w_lastBeat;

         // RAM read data is valid the cycle after the issue
         if (r_inflight) begin
            r_bufData[r_wrIdx] <= bus.ram_dout;
            r_bufLast[r_wrIdx] <= r_inflightLast;
            r_wrIdx            <= ~r_wrIdx;
         end
         if (w_pop) begin
            r_rdIdx <= ~r_rdIdx;
         end
         r_count <= r_count + 2'(r_inflight) - 2'(w_pop);

         case (r_state)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  if (w_cmdReject) begin
`ifndef RAM_INIT_ADDR_WRAP_EN
                     r_err <= 1'b1;
`endif
                  end else begin
                     r_ptr       <= bus.cmd_addr;
                     r_beatsLeft <= bus.cmd_len;
                     r_state     <= bus.cmd_wr ? ST_WRITE : ST_READ;
                  end
               end
            end

            ST_WRITE: begin
               if (w_writeBeat) begin
                  r_ptr <= r_ptr + ADDR_W'(1);
                  if (w_lastBeat) begin
                     r_state <= ST_IDLE;
                     r_done  <= 1'b1;
                  end else begin
                     r_beatsLeft <= r_beatsLeft - ADDR_W'(1);
                  end
               end
            end

            ST_READ: begin
               if (w_readIssue) begin
                  r_ptr <= r_ptr + ADDR_W'(1);
                  if (w_lastBeat) begin
                     r_state <= ST_DRAIN;
                  end else begin
                     r_beatsLeft <= r_beatsLeft - ADDR_W'(1);
                  end
               end
            end

            ST_DRAIN: begin
               // the last-flagged entry can only reach the head in DRAIN
               if (w_pop && bus.rdata_last) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_initiator
// Purpose  : Directed self-checking bench for ram_port_initiator with a
//            behavioural registered-read RAM port attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_initiator;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   logic [7:0] ramMem [8];   // RAM contents
   logic [7:0] expMem [8];   // what the bench has written so far

   ram_port_initiator_if #(.ADDR_W(3), .DATA_W(8)) bus ();

   ram_port_initiator #(.ADDR_W(3), .DATA_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // registered-read RAM port
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_wr) ramMem[bus.ram_addr] <= bus.ram_din;
         else            bus.ram_dout <= ramMem[bus.ram_addr];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"},   32'(bus.cmd_ready),   1);
      check({tag, "_wdata_ready"}, 32'(bus.wdata_ready), 0);
      check({tag, "_rdata_valid"}, 32'(bus.rdata_valid), 0);
      check({tag, "_rdata"},       32'(bus.rdata),       0);
      check({tag, "_rdata_last"},  32'(bus.rdata_last),  0);
      check({tag, "_done"},        32'(bus.done),        0);
      check({tag, "_err"},         32'(bus.err),         0);
      check({tag, "_ram_en"},      32'(bus.ram_en),      0);
      check({tag, "_ram_wr"},      32'(bus.ram_wr),      0);
      check({tag, "_ram_addr"},    32'(bus.ram_addr),    0);
      check({tag, "_ram_din"},     32'(bus.ram_din),     0);
   endtask

   task automatic present_cmd(input bit wr, input logic [2:0] addr, input logic [2:0] len);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = wr;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      #1;
      check("cmd_ready_offer", 32'(bus.cmd_ready), 1);
   endtask

   // Write burst: data beat i = base + i*step, valid on every gap-th cycle.
   // Returns inside the done cycle.
   task automatic write_loop(input logic [2:0] addr, input int len, input int gap,
                             input logic [7:0] base, input logic [7:0] step);
      int         beat    = 0;
      int         lastCyc = -10;
      bit         sawDone = 0;
      logic [7:0] d;
      logic [2:0] a;
      for (int cyc = 0; cyc < 64 && !sawDone; cyc++) begin
         @(negedge clk);
         bus.cmd_valid   = 1'b0;
         d               = base + 8'(beat) * step;
         bus.wdata_valid = (beat <= len) && (cyc % gap == 0);
         bus.wdata       = bus.wdata_valid ? d : 8'h00;
         #1;
         if (bus.done) begin
            sawDone = 1;
            check("wr_done_beats", beat, len + 1);
            check("wr_done_latency", cyc - lastCyc, 1);
            check("wr_done_err", 32'(bus.err), 0);
            check("wr_done_ready", 32'(bus.wdata_ready), 0);
         end else begin
            check("wr_ready", 32'(bus.wdata_ready), 1);
         end
         check("wr_ram_en", 32'(bus.ram_en), 32'(bus.wdata_valid));
         if (bus.wdata_valid) begin
            a = addr + 3'(beat);
            check("wr_ram_wr", 32'(bus.ram_wr), 1);
            check("wr_ram_addr", 32'(bus.ram_addr), 32'(a));
            check("wr_ram_din", 32'(bus.ram_din), 32'(d));
            expMem[a] = d;
            beat++;
            lastCyc = cyc;
         end else begin
            check("wr_idle_addr", 32'(bus.ram_addr), 0);
            check("wr_idle_din", 32'(bus.ram_din), 0);
         end
      end
      bus.wdata_valid = 1'b0;
      check("wr_done_seen", 32'(sawDone), 1);
   endtask

   // Read burst scoreboard; rdata_ready toggles 1/0 when toggle is set.
   // Returns inside the done cycle.
   task automatic read_loop(input logic [2:0] addr, input int len, input bit toggle);
      int         k = 0, issued = 0, cnt = 0, infl = 0;
      int         firstValid = -1, firstIssue = -1, lastPopCyc = -10;
      bit         sawDone = 0, prevHeld = 0, pop;
      logic [7:0] prevData = 8'h00;
      logic [2:0] a;
      for (int cyc = 0; cyc < 64 && !sawDone; cyc++) begin
         @(negedge clk);
         bus.cmd_valid   = 1'b0;
         bus.rdata_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         #1;
         pop = bus.rdata_valid && bus.rdata_ready;
         if (prevHeld) check("rd_hold", 32'(bus.rdata), 32'(prevData));
         if (bus.rdata_valid && firstValid < 0) firstValid = cyc;
         if (pop) begin
            a = addr + 3'(k);
            check("rd_data", 32'(bus.rdata), 32'(expMem[a]));
            check("rd_last", 32'(bus.rdata_last), 32'(k == len));
            k++;
            lastPopCyc = cyc;
         end
         if (bus.ram_en) begin
            if (firstIssue < 0) firstIssue = cyc;
            a = addr + 3'(issued);
            check("rd_ram_wr", 32'(bus.ram_wr), 0);
            check("rd_ram_addr", 32'(bus.ram_addr), 32'(a));
            check("rd_occupancy", 32'((cnt + infl - int'(pop)) < 2), 1);
            check("rd_issue_count", 32'(issued <= len), 1);
            issued++;
         end else begin
            check("rd_idle_addr", 32'(bus.ram_addr), 0);
         end
         if (bus.done) begin
            sawDone = 1;
            check("rd_done_beats", k, len + 1);
            check("rd_done_after_last", cyc - lastPopCyc, 1);
            check("rd_done_err", 32'(bus.err), 0);
            check("rd_done_cmd_ready", 32'(bus.cmd_ready), 1);
         end else begin
            check("rd_busy_cmd_ready", 32'(bus.cmd_ready), 0);
         end
         prevHeld = bus.rdata_valid && !bus.rdata_ready;
         prevData = bus.rdata;
         cnt  = cnt + infl - int'(pop);
         infl = int'(bus.ram_en);
      end
      check("rd_done_seen", 32'(sawDone), 1);
      check("rd_first_issue", firstIssue, 0);
      check("rd_first_valid", firstValid, 2);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.cmd_valid   = 1'b0;
      bus.cmd_wr      = 1'b0;
      bus.cmd_addr    = 3'd0;
      bus.cmd_len     = 3'd0;
      bus.wdata_valid = 1'b0;
      bus.wdata       = 8'h00;
      bus.rdata_ready = 1'b0;
      for (int i = 0; i < 8; i++) expMem[i] = 8'h00;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      rst_n = 1'b1;

      // gapped write fills the whole RAM: 0x30..0x37
      present_cmd(1'b1, 3'd0, 3'd7);
      write_loop(3'd0, 7, 3, 8'h30, 8'h01);

      // full-rate write A1,B2,C3,D4 at address 2..5
      present_cmd(1'b1, 3'd2, 3'd3);
      write_loop(3'd2, 3, 1, 8'hA1, 8'h11);

      // read back 2..5 with sink always ready
      present_cmd(1'b0, 3'd2, 3'd3);
      read_loop(3'd2, 3, 1'b0);

      // back-to-back: new read offered in the done cycle
      check("b2b_done", 32'(bus.done), 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = 1'b0;
      bus.cmd_addr  = 3'd0;
      bus.cmd_len   = 3'd7;
      #1;
      check("b2b_cmd_ready", 32'(bus.cmd_ready), 1);
      read_loop(3'd0, 7, 1'b1);

      // boundary crossing at the top of the address space
      present_cmd(1'b0, 3'd6, 3'd3);
`ifdef RAM_INIT_ADDR_WRAP_EN
      read_loop(3'd6, 3, 1'b0);
`else
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      check("bnd_err", 32'(bus.err), 1);
      check("bnd_done", 32'(bus.done), 0);
      check("bnd_ram_en", 32'(bus.ram_en), 0);
      check("bnd_cmd_ready", 32'(bus.cmd_ready), 1);
      @(negedge clk);
      #1;
      check("bnd_err_clear", 32'(bus.err), 0);
      check("bnd_ram_en2", 32'(bus.ram_en), 0);
`endif

      // reset in DRAIN with two beats buffered
      bus.rdata_ready = 1'b0;
      present_cmd(1'b0, 3'd0, 3'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      check("mr_issue0_en", 32'(bus.ram_en), 1);
      check("mr_issue0_addr", 32'(bus.ram_addr), 0);
      @(negedge clk);
      #1;
      check("mr_issue1_en", 32'(bus.ram_en), 1);
      check("mr_issue1_addr", 32'(bus.ram_addr), 1);
      @(negedge clk);
      #1;
      check("mr_drain_no_access", 32'(bus.ram_en), 0);
      check("mr_valid1", 32'(bus.rdata_valid), 1);
      @(negedge clk);
      #1;
      check("mr_valid2", 32'(bus.rdata_valid), 1);
      check("mr_head", 32'(bus.rdata), 32'h30);
      check("mr_busy", 32'(bus.cmd_ready), 0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mr_async");
      repeat (2) begin
         @(negedge clk);
         #1;
         check("mr_no_done", 32'(bus.done), 0);
      end
      rst_n = 1'b1;

      // read after reset still returns correct data
      present_cmd(1'b0, 3'd4, 3'd1);
      read_loop(3'd4, 1, 1'b0);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
